// File: rtl/alien_fleet.sv
// alien_fleet: invader grid bitmap, march/drop step engine, pixel render and laser kill detection.
// Build with ALIEN_SPEEDUP_EN defined to shorten the step interval as aliens die.
module alien_fleet #(
  parameter int ROWS = 4,
  parameter int COLS = 8,
  parameter int CELL_W = 32,
  parameter int CELL_H = 32,
  parameter int SPRITE_SCALE = 2,
  parameter int START_X = 64,
  parameter int START_Y = 48,
  parameter int STEP_X = 8,
  parameter int DROP_Y = 16,
  parameter int X_MIN = 16,
  parameter int X_MAX = 624,
  parameter int LAND_Y = 416,
  parameter int MOVE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       laser_gfx,
  output logic       alien_gfx,
  output logic       hit_alien,
  output logic [7:0] score,
  output logic [5:0] alive_count,
  output logic       fleet_cleared,
  output logic       fleet_landed
);
  localparam int N = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(CELL_W);
  localparam int CH = $clog2(CELL_H);
  localparam int SS = $clog2(SPRITE_SCALE);
  typedef enum logic {RIGHT, LEFT} dir_t;
  dir_t dir;
  logic vs_q, vs_qq, tick, anim, kill_lock, frozen, kill, pix_c, step;
  logic in_grid, right_hit, left_hit, edge_hit;
  logic [10:0] fleet_x, fleet_y, rel_x, rel_y, col, row, sx, sy, nx, ny;
  logic [N-1:0] alive;
  logic [IW-1:0] idx;
  logic [7:0] frame_cnt, last, pts, row_bits;
  logic [8:0] sum;
  logic [1:0] kind;
  // Sprite rows 3 and 4 are fully lit in every type and frame.
  function automatic logic [7:0] sprite(input logic [1:0] k, input logic f, input logic [2:0] y);
    logic [63:0] bmp;
    bmp = k == 2'd0 ? (f ? 64'h183C7EFFFF5A8142 : 64'h183C7EFFFF245AA5) :
          k == 2'd1 ? (f ? 64'h2499BDFFFF3C2481 : 64'h24183CFFFF3C2442) :
                      (f ? 64'h3C7EDBFFFF245A24 : 64'h3C7EDBFFFF66DB81);
    return 8'(bmp >> {~y, 3'b000});
  endfunction
  assign tick = vs_q & ~vs_qq;
  assign rel_x = {1'b0, hpos} - fleet_x;
  assign rel_y = {1'b0, vpos} - fleet_y;
  assign col = rel_x >> CW;
  assign row = rel_y >> CH;
  assign sx = (rel_x & 11'(CELL_W - 1)) >> SS;
  assign sy = (rel_y & 11'(CELL_H - 1)) >> SS;
  assign in_grid = ({1'b0, hpos} >= fleet_x) & ({1'b0, vpos} >= fleet_y) &
                   (col < 11'(COLS)) & (row < 11'(ROWS));
  assign idx = IW'(row * 11'(COLS) + col);
  assign kind = row == 11'd0 ? 2'd0 : row <= 11'(ROWS / 2) ? 2'd1 : 2'd2;
  assign row_bits = sprite(kind, anim, sy[2:0]);
  assign pix_c = in_grid & (sx < 11'd8) & (sy < 11'd8) & alive[idx] & row_bits[~sx[2:0]];
  assign fleet_cleared = alive_count == 6'd0;
  assign frozen = fleet_landed | fleet_cleared;
  assign kill = pix_c & laser_gfx & ~kill_lock & ~frozen;
  assign pts = kind == 2'd0 ? 8'd30 : kind == 2'd1 ? 8'd20 : 8'd10;
  assign sum = {1'b0, score} + {1'b0, pts};
`ifdef ALIEN_SPEEDUP_EN
  assign last = 8'(alive_count >> 2);
`else
  assign last = 8'(MOVE_FRAMES - 1);
`endif
  // >= keeps the engine stepping if a kill shrinks the interval below frame_cnt.
  assign step = tick & ~frozen & (frame_cnt >= last);
  assign right_hit = fleet_x + 11'(COLS * CELL_W + STEP_X) > 11'(X_MAX);
  assign left_hit = fleet_x < 11'(X_MIN + STEP_X);
  assign edge_hit = dir == RIGHT ? right_hit : left_hit;
  assign nx = edge_hit ? fleet_x : dir == RIGHT ? fleet_x + 11'(STEP_X) : fleet_x - 11'(STEP_X);
  assign ny = edge_hit ? fleet_y + 11'(DROP_Y) : fleet_y;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      vs_qq <= 1'b0;
      fleet_x <= 11'(START_X);
      fleet_y <= 11'(START_Y);
      dir <= RIGHT;
      alive <= {N{1'b1}};
      alive_count <= 6'(N);
      score <= 8'd0;
      anim <= 1'b0;
      frame_cnt <= 8'd0;
      kill_lock <= 1'b0;
      alien_gfx <= 1'b0;
      hit_alien <= 1'b0;
      fleet_landed <= 1'b0;
    end else begin
      vs_q <= vsync;
      vs_qq <= vs_q;
      alien_gfx <= pix_c;
      hit_alien <= kill;
      if (tick && !frozen) frame_cnt <= step ? 8'd0 : frame_cnt + 8'd1;
      if (step) begin
        fleet_x <= nx;
        fleet_y <= ny;
        anim <= ~anim;
        if (edge_hit) dir <= dir == RIGHT ? LEFT : RIGHT;
        if (ny + 11'(ROWS * CELL_H) >= 11'(LAND_Y)) fleet_landed <= 1'b1;
      end
      if (kill) begin
        alive[idx] <= 1'b0;
        alive_count <= alive_count - 6'd1;
        score <= sum[8] ? 8'hFF : sum[7:0];
      end
      kill_lock <= kill | (kill_lock & ~tick);
    end
  end
endmodule

// File: tb/tb_alien_fleet.sv
// tb_alien_fleet: randomized bench against a behavioural fleet model.
module tb_alien_fleet;
  localparam int ROWS = 4, COLS = 8, CELL_W = 32, CELL_H = 32, SCALE = 2;
  logic clk = 0, rst_n = 1, vsync = 0, laser_gfx = 0;
  logic [9:0] hpos = 0, vpos = 0;
  logic alien_gfx, hit_alien, fleet_cleared, fleet_landed;
  logic [7:0] score;
  logic [5:0] alive_count;
  int checks = 0, errors = 0;
  int ox, oy, fcnt, cnt, sc;
  bit left, lock, landed;
  bit alive [ROWS][COLS];

  alien_fleet dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .hpos(hpos), .vpos(vpos),
    .laser_gfx(laser_gfx), .alien_gfx(alien_gfx), .hit_alien(hit_alien),
    .score(score), .alive_count(alive_count), .fleet_cleared(fleet_cleared),
    .fleet_landed(fleet_landed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    ox = 64; oy = 48; fcnt = 0; cnt = ROWS * COLS; sc = 0;
    left = 0; lock = 0; landed = 0;
    foreach (alive[r, c]) alive[r][c] = 1;
  endfunction

  // 0 = dark, 1 = lit, 2 = inside a live sprite but on a row whose art is unspecified
  function automatic int m_pix(int x, int y);
    int rx, ry, c, r, sx, sy;
    rx = x - ox; ry = y - oy;
    if (rx < 0 || ry < 0) return 0;
    c = rx / CELL_W; r = ry / CELL_H;
    sx = (rx % CELL_W) / SCALE; sy = (ry % CELL_H) / SCALE;
    if (c >= COLS || r >= ROWS || sx >= 8 || sy >= 8) return 0;
    if (!alive[r][c]) return 0;
    return (sy == 3 || sy == 4) ? 1 : 2;
  endfunction

  function automatic void m_tick();
    int interval;
`ifdef ALIEN_SPEEDUP_EN
    interval = 1 + (cnt >> 2);
`else
    interval = 8;
`endif
    lock = 0;
    if (landed || cnt == 0) return;
    if (fcnt < interval - 1) begin
      fcnt++;
      return;
    end
    fcnt = 0;
    if (!left) begin
      if (ox + COLS * CELL_W + 8 > 624) begin oy += 16; left = 1; end
      else ox += 8;
    end else begin
      if (ox - 8 < 16) begin oy += 16; left = 0; end
      else ox -= 8;
    end
    if (oy + ROWS * CELL_H >= 416) landed = 1;
  endfunction

  task automatic status(input string tag);
    check({tag, "_score"}, score, sc);
    check({tag, "_count"}, alive_count, cnt);
    check({tag, "_cleared"}, fleet_cleared, cnt == 0);
    check({tag, "_landed"}, fleet_landed, landed);
  endtask

  task automatic cyc(input int x, input int y, input bit l);
    int p, r, c;
    bit k;
    p = m_pix(x, y);
    if (p == 2) l = 0;
    hpos = 10'(x); vpos = 10'(y); laser_gfx = l;
    k = (p == 1) && l && !lock && !landed && cnt != 0;
    @(posedge clk); #1;
    if (k) begin
      r = (y - oy) / CELL_H; c = (x - ox) / CELL_W;
      alive[r][c] = 0; cnt--; lock = 1;
      sc += (r == 0) ? 30 : (r <= ROWS / 2) ? 20 : 10;
      if (sc > 255) sc = 255;
    end
    if (p != 2) check("gfx", alien_gfx, p);
    check("hit", hit_alien, k);
    status("pix");
    laser_gfx = 0;
  endtask

  task automatic frame();
    hpos = 0; vpos = 0; laser_gfx = 0; vsync = 1;
    @(posedge clk); #1;
    vsync = 0;
    @(posedge clk); #1;
    m_tick();
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    check("rst_count", alive_count, ROWS * COLS);
    check("rst_score", score, 0);
    check("rst_gfx", alien_gfx, 0);
    check("rst_hit", hit_alien, 0);
    check("rst_flags", {fleet_landed, fleet_cleared}, 0);
    vsync = 0; laser_gfx = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    m_reset();
  endtask

  task automatic shoot_random();
    int r, c;
    if (cnt == 0) return;
    do begin r = $urandom_range(ROWS - 1); c = $urandom_range(COLS - 1); end while (!alive[r][c]);
    cyc(ox + c * CELL_W + $urandom_range(15), oy + r * CELL_H + 6 + $urandom_range(3), 1);
  endtask

  initial begin
    m_reset();
    do_reset();
    cyc(68, 55, 0);
    cyc(68, 150, 1);
    cyc(68, 150, 0);
    frame();
    cyc(68, 150, 0);
    cyc(100, 55, 1);
    cyc(100, 87, 1);
    frame();
    cyc(100, 87, 1);
    check("two_kill_score", score, 60);
    repeat (20) begin
      frame();
      cyc($urandom_range(699), $urandom_range(499), $urandom_range(1));
    end
    // Undisturbed march all the way to the landing line.
    do_reset();
    for (int f = 0; f < 7000 && !landed; f++) begin
      frame();
      cyc(ox + 4 + CELL_W * $urandom_range(COLS - 1), oy + 7, 0);
      cyc(ox - 1, oy + 7, 0);
      cyc(ox + 4, oy - 1, 0);
    end
    check("landed_reached", fleet_landed, 1);
    repeat (20) begin
      frame();
      cyc(ox + 4, oy + 7, 1);
      cyc(ox - 1, oy + 7, 0);
    end
    // Random shooting until the fleet is wiped out.
    do_reset();
    for (int f = 0; f < 800; f++) begin
      frame();
      cyc($urandom_range(699), $urandom_range(499), $urandom_range(1));
      if ($urandom_range(3) != 0) shoot_random();
      if ($urandom_range(3) == 0) shoot_random();
      cyc(ox + 4, oy + 7, 0);
      cyc(ox - 1, oy + 8, 0);
      if ((cnt == 0 || landed) && $urandom_range(15) == 0) break;
    end
    status("end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
